// File: rtl/skid_stage.sv
// Two-entry elastic register stage with valid/ready on both sides.
// in_ready, out_valid, out_data and occupancy are all driven from flops only.
module skid_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = S_TWO;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // in_ready is low here, so only the consumer side can move
        if (out_fire) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_valid = (state_q != S_EMPTY);
  assign in_ready  = (state_q != S_TWO);
  assign out_data  = main_q;

  always_comb begin
    occupancy = 2'd0;
    if (state_q == S_ONE) occupancy = 2'd1;
    if (state_q == S_TWO) occupancy = 2'd2;
  end

endmodule

// File: tb/tb_skid_stage.sv
// Directed bench for skid_stage: reset, single word, streaming, stall/skid,
// simultaneous fire, idle X on input, and reset while full.
module tb_skid_stage;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int checks = 0;
  int errors = 0;

  skid_stage #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b0;

    // asynchronous reset with no clock edge
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);

    @(posedge clk);
    #2;
    in_valid = 1'b0;
    reset    = 1'b1;

    // single word
    in_valid = 1'b1; in_data = 32'd10; out_ready = 1'b1;
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  out_data,       32'd10);
    check("single_occ",   32'(occupancy), 32'd1);
    in_valid = 1'b0;
    tick();
    check("single_drain_valid", 32'(out_valid), 32'd0);
    check("single_drain_occ",   32'(occupancy), 32'd0);

    // streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      check("stream_data",  out_data,       32'(i));
      check("stream_ready", 32'(in_ready),  32'd1);
      check("stream_occ",   32'(occupancy), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_occ", 32'(occupancy), 32'd0);

    // stall and skid
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd5;
    tick();
    check("stall_occ1",  32'(occupancy), 32'd1);
    check("stall_data5", out_data,       32'd5);
    in_data = 32'd6;
    tick();
    check("stall_occ2",   32'(occupancy), 32'd2);
    check("stall_nready", 32'(in_ready),  32'd0);
    check("stall_hold5",  out_data,       32'd5);
    in_data = 32'd7;
    tick();
    check("stall_reject_occ", 32'(occupancy), 32'd2);
    check("stall_reject_data", out_data,      32'd5);
    check("stall_reject_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("drain_head5", out_data, 32'd5);
    tick();
    check("drain_head6",  out_data,       32'd6);
    check("drain_occ1",   32'(occupancy), 32'd1);
    check("drain_ready",  32'(in_ready),  32'd1);
    in_valid = 1'b1; in_data = 32'd7;
    tick();
    check("drain_head7", out_data,       32'd7);
    check("drain_occ7",  32'(occupancy), 32'd1);
    in_valid = 1'b0;
    tick();
    check("drain_empty", 32'(occupancy), 32'd0);

    // simultaneous fire while holding one word
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd8;
    tick();
    check("sim_main8", out_data, 32'd8);
    out_ready = 1'b1; in_data = 32'd9;
    tick();
    check("sim_data9", out_data,       32'd9);
    check("sim_occ",   32'(occupancy), 32'd1);
    check("sim_ready", 32'(in_ready),  32'd1);
    in_valid = 1'b0;
    tick();
    check("sim_empty", 32'(occupancy), 32'd0);

    // unknown input data while idle must not reach the output register
    out_ready = 1'b0;
    in_data = 'x;
    tick();
    check("idle_x_data",  out_data,       32'd9);
    check("idle_x_valid", 32'(out_valid), 32'd0);

    // reset while full
    in_valid = 1'b1; in_data = 32'd11;
    tick();
    in_data = 32'd12;
    tick();
    check("full_occ", 32'(occupancy), 32'd2);
    check("full_head", out_data,      32'd11);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready),  32'd1);
    check("midrst_data",  out_data,       32'd0);
    check("midrst_occ",   32'(occupancy), 32'd0);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_data",  out_data,       32'd0);
    tick();
    check("post_rst_valid2", 32'(out_valid), 32'd0);
    check("post_rst_data2",  out_data,       32'd0);
    in_valid = 1'b1; in_data = 32'd13;
    tick();
    check("post_rst_accept", out_data,        32'd13);
    check("post_rst_occ",    32'(occupancy),  32'd1);
    in_valid = 1'b0;
    tick();
    check("final_empty", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
